// File: rtl/key_schedule_if.sv
// Key-schedule request/readback bundle: the master issues expansion requests and
// reads round keys, the slave (key_schedule) expands and serves them.
interface key_schedule_if;
  // Handshake: start is a one-cycle request accepted only while busy=0. Requests
  // seen while busy=1 are dropped. done pulses once per accepted request, and
  // keys_valid then stays high until the next accepted request or reset.
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  modport master (
    output start, key_in, rk_idx,
    input  busy, done, keys_valid, rk_out
  );

  modport slave (
    input  start, key_in, rk_idx,
    output busy, done, keys_valid, rk_out
  );
endinterface

// File: rtl/key_schedule.sv
// AES-128 round-key expansion into a register file, one round per cycle through a
// single keyexpand instance. Define KEY_SCHEDULE_RDREG_EN for a registered rk_out.
module keyexpand (
  input  logic [127:0] key,
  input  logic [3:0]   rc,
  output logic [127:0] keyout
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] rcon;
  logic [7:0] acc;

  // Byte (row r, col c) lives at bit 127-8*(4r+c); each row is a running XOR
  // across columns, seeded with the rotated/substituted last column.
  always_comb begin
    keyout = '0;
    acc    = 8'h00;
    rcon   = 8'h01;
    for (int i = 0; i < 10; i++) begin
      if (4'(i) < rc) rcon = xtime(rcon);
    end
    for (int r = 0; r < 4; r++) begin
      acc = sbox(key[127-8*(4*((r+1)%4)+3) -: 8]) ^ ((r == 0) ? rcon : 8'h00);
      for (int c = 0; c < 4; c++) begin
        acc = acc ^ key[127-8*(4*r+c) -: 8];
        keyout[127-8*(4*r+c) -: 8] = acc;
      end
    end
  end
endmodule

module key_schedule #(
  parameter int ROUNDS = 10
) (
  input  logic           clk,
  input  logic           reset,
  key_schedule_if.slave  ks,
  output logic [1:0]     dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic         keys_valid_q;
  logic [127:0] rk [0:ROUNDS];
  logic [127:0] ke_key, ke_out, rd_data;

  keyexpand u_keyexpand (
    .key    (ke_key),
    .rc     (cnt),
    .keyout (ke_out)
  );

  always_comb begin
    ke_key = '0;
    for (int i = 0; i <= ROUNDS; i++) begin
      if (cnt == 4'(i)) ke_key = rk[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ks.start) state_nxt = EXPAND;
      EXPAND:  if (cnt + 4'd1 == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= ROUNDS; i++) rk[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (ks.start) begin
            rk[0]        <= ks.key_in;
            cnt          <= 4'd0;
            keys_valid_q <= 1'b0;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= ROUNDS; i++) begin
            if (cnt + 4'd1 == 4'(i)) rk[i] <= ke_out;
          end
          if (cnt != LAST) cnt <= cnt + 4'd1;
        end
        DONE: keys_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Indices beyond ROUNDS match no entry and read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= ROUNDS; i++) begin
      if (ks.rk_idx == 4'(i)) rd_data = rk[i];
    end
  end

`ifdef KEY_SCHEDULE_RDREG_EN
  logic [127:0] rk_out_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rk_out_q <= '0;
    else       rk_out_q <= rd_data;
  end
  assign ks.rk_out = rk_out_q;
`else
  assign ks.rk_out = rd_data;
`endif

  assign ks.busy       = (state != IDLE);
  assign ks.done       = (state == DONE);
  assign ks.keys_valid = keys_valid_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: FIPS-197 vectors, busy/reset/back-to-back scenarios and
// random keys checked against a word-oriented AES-128 key expansion model.
module tb_key_schedule;
  localparam int ROUNDS = 10;
  localparam logic [127:0] FIPS_KEY  = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
  localparam logic [127:0] FIPS_RK1  = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
  localparam logic [127:0] FIPS_RK10 = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;
  // Zero-key round-10 key as FIPS-197 lists it (word/column order).
  localparam logic [127:0] ZERO_RK10_COLS = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  key_schedule_if ks();

  key_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .ks        (ks),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned start_edge = 0;
  always @(posedge clk) edge_cnt++;
  always @(negedge clk) if (ks.done) done_cnt++;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sb [0:255];
  logic [127:0] model_rk [0:ROUNDS];

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] d;
    d = {x, x} << k;
    return d[15:8];
  endfunction

  // S-box table from the generator walk: p runs over all units by multiplying
  // by 3, q tracks its inverse by dividing by 3.
  function automatic void build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endfunction

  // Column-major (FIPS word order) <-> row-major bus layout.
  function automatic logic [127:0] transpose(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(4*r+c) -: 8] = x[127-8*(4*c+r) -: 8];
    return y;
  endfunction

  function automatic void model_expand(input logic [127:0] key);
    logic [31:0]  w [0:43];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] cols;
    cols = transpose(key);
    for (int i = 0; i < 4; i++) w[i] = cols[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= ROUNDS; k++)
      model_rk[k] = transpose({w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    ks.rk_idx = idx;
`ifdef KEY_SCHEDULE_RDREG_EN
    @(posedge clk);
`endif
    #1;
    val = ks.rk_out;
  endtask

  task automatic start_key(input logic [127:0] key);
    @(posedge clk); #1;
    ks.start  = 1'b1;
    ks.key_in = key;
    @(posedge clk); #1;
    ks.start  = 1'b0;
    start_edge = edge_cnt;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ks.done) begin
        lat = int'(edge_cnt - start_edge) + 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 128'(ks.done), 128'd1);
    check({tag, "_latency"}, 128'(lat), 128'(ROUNDS + 1));
    @(negedge clk);
    check({tag, "_done_pulse"}, 128'(ks.done), 128'd0);
    check({tag, "_keys_valid"}, 128'(ks.keys_valid), 128'd1);
    check({tag, "_busy_idle"}, 128'(ks.busy), 128'd0);
  endtask

  task automatic check_keys(input string tag, input logic [127:0] key);
    logic [127:0] got;
    model_expand(key);
    for (int i = 0; i <= ROUNDS; i++) exp_q.push_back(model_rk[i]);
    for (int i = 0; i <= ROUNDS; i++) begin
      read_rk(4'(i), got);
      check($sformatf("%s_rk%0d", tag, i), got, exp_q.pop_front());
    end
  endtask

  task automatic check_fips(input string tag);
    logic [127:0] got;
    read_rk(4'd0, got);  check({tag, "_fips_rk0"}, got, FIPS_KEY);
    read_rk(4'd1, got);  check({tag, "_fips_rk1"}, got, FIPS_RK1);
    read_rk(4'd10, got); check({tag, "_fips_rk10"}, got, FIPS_RK10);
    check_keys(tag, FIPS_KEY);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got, key;
    int unsigned  dc;

    ks.start  = 1'b0;
    ks.key_in = '0;
    ks.rk_idx = 4'd0;
    build_sbox();

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 128'(ks.busy), 128'd0);
    check("rst_done", 128'(ks.done), 128'd0);
    check("rst_keys_valid", 128'(ks.keys_valid), 128'd0);
    check("rst_rk_out", ks.rk_out, 128'd0);
    reset = 1'b0;

    // FIPS-197 vector
    dc = done_cnt;
    start_key(FIPS_KEY);
    @(negedge clk);
    check("fips_busy", 128'(ks.busy), 128'd1);
    check("fips_kv_low", 128'(ks.keys_valid), 128'd0);
    wait_done("fips");
    check("fips_one_done", 128'(done_cnt - dc), 128'd1);
    check_fips("fips");

    // Out-of-range reads
    for (int i = ROUNDS + 1; i < 16; i++) begin
      read_rk(4'(i), got);
      check($sformatf("oor_rk%0d", i), got, 128'd0);
    end
    check("oor_keys_valid", 128'(ks.keys_valid), 128'd1);

    // Read latency
    read_rk(4'd0, got);
    ks.rk_idx = 4'd1;
    #1;
`ifdef KEY_SCHEDULE_RDREG_EN
    check("rdlat_hold", ks.rk_out, FIPS_KEY);
    @(posedge clk); #1;
    check("rdlat_reg", ks.rk_out, FIPS_RK1);
`else
    check("rdlat_comb", ks.rk_out, FIPS_RK1);
`endif

    // Start while busy is ignored
    dc = done_cnt;
    start_key(FIPS_KEY);
    repeat (2) @(posedge clk);
    #1;
    ks.start  = 1'b1;
    ks.key_in = '1;
    @(posedge clk); #1;
    ks.start  = 1'b0;
    wait_done("busy");
    repeat (3) @(negedge clk);
    check("busy_one_done", 128'(done_cnt - dc), 128'd1);
    check_fips("busy");

    // Reset mid-expansion
    start_key(FIPS_KEY);
    ks.rk_idx = 4'd0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 128'(ks.busy), 128'd0);
    check("abort_done", 128'(ks.done), 128'd0);
    check("abort_keys_valid", 128'(ks.keys_valid), 128'd0);
    check("abort_rk_out", ks.rk_out, 128'd0);
    dc = done_cnt;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", 128'(done_cnt - dc), 128'd0);
    check("abort_idle", 128'(ks.busy), 128'd0);
    start_key(FIPS_KEY);
    wait_done("after_abort");
    check_fips("after_abort");

    // Back-to-back: random key, then the zero key the cycle after done
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(key);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ks.done) break;
    end
    check("b2b_first_done", 128'(ks.done), 128'd1);
    @(posedge clk); #1;
    check("b2b_kv_before", 128'(ks.keys_valid), 128'd1);
    ks.start  = 1'b1;
    ks.key_in = '0;
    @(posedge clk); #1;
    ks.start  = 1'b0;
    start_edge = edge_cnt;
    check("b2b_kv_dropped", 128'(ks.keys_valid), 128'd0);
    wait_done("b2b");
    read_rk(4'd10, got);
    check("b2b_zero_rk10", got, transpose(ZERO_RK10_COLS));
    check_keys("b2b", '0);

    // Random keys and random reads
    for (int n = 0; n < 6; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_key(key);
      wait_done($sformatf("rnd%0d", n));
      check_keys($sformatf("rnd%0d", n), key);
      for (int j = 0; j < 4; j++) begin
        logic [3:0] idx;
        idx = 4'($urandom_range(0, 15));
        read_rk(idx, got);
        check($sformatf("rnd%0d_rd%0d", n, idx), got,
              (int'(idx) <= ROUNDS) ? model_rk[idx] : 128'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
